icc_framer: RTL and testbench

ICC_FRAMER -- requirements
Module: icc_framer

---
 rtl/icc_framer.sv | 208 ++++++++++++++++++++
 tb/tb_icc_framer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icc_framer.sv
`timescale 1ns/1ps
// icc_framer: inter-chip comma framer for a GT transceiver pair.
// TX side inserts a K28.5 comma word every 2^COMMA_LOG2 cycles and
// idle-fills with commas when no payload is offered. RX side hunts for
// commas, declares lock after LOCK_COUNT consecutive good commas, delivers
// data words while locked, and keeps a saturating error counter.
//
// Handshake: a payload word moves when tx_valid & tx_ready are both high
// on a rising edge of usrclk. tx_ready depends only on the slot counter,
// never on tx_valid; the producer holds tx_data/tx_valid until accepted.
module icc_framer #(
   parameter int DWIDTH     = 32,
   parameter int COMMA_LOG2 = 4,
   parameter int LOCK_COUNT = 4,
   parameter int ERRCNT_W   = 16
) (
   input  logic                  usrclk,
   input  logic                  reset,
   input  logic [DWIDTH-1:0]     tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DWIDTH-1:0]     gt_txdata,
   output logic [DWIDTH/8-1:0]   gt_txcharisk,
   input  logic [DWIDTH-1:0]     gt_rxdata,
   input  logic [DWIDTH/8-1:0]   gt_rxcharisk,
   input  logic [DWIDTH/8-1:0]   gt_rxdisperr,
   input  logic [DWIDTH/8-1:0]   gt_rxnotintable,
   output logic [DWIDTH-1:0]     rx_data,
   output logic                  rx_valid,
   output logic                  locked,
   input  logic                  err_clear,
   output logic [ERRCNT_W-1:0]   err_count,
   output logic [1:0]            rx_state
);

   localparam int DBYTE  = DWIDTH / 8;
   localparam int WDOG_W = COMMA_LOG2 + 1;
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   localparam logic [DWIDTH-1:0] COMMA = {DBYTE{8'hBC}};
   localparam logic [DBYTE-1:0]  K_ALL = '1;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_e;

   // ---------------------------------------------------------------- TX
   logic [COMMA_LOG2-1:0] slot_q, slot_d;
   logic [DWIDTH-1:0]     txdata_q, txdata_d;
   logic [DBYTE-1:0]      txk_q, txk_d;
   logic                  tx_take;

   // Slot 0 is reserved for the comma; payload is only taken in other slots.
   always_comb begin
      slot_d   = slot_q + 1'b1;
      tx_ready = (slot_q != '0);
      tx_take  = tx_valid & tx_ready;
      if (tx_take) begin
         txdata_d = tx_data;
         txk_d    = '0;
      end else begin
         txdata_d = COMMA;
         txk_d    = K_ALL;
      end
   end

   // TX slot counter and registered GT word.
   always_ff @(posedge usrclk) begin
      if (reset) begin
         slot_q   <= '0;
         txdata_q <= COMMA;
         txk_q    <= K_ALL;
      end else begin
         slot_q   <= slot_d;
         txdata_q <= txdata_d;
         txk_q    <= txk_d;
      end
   end

   assign gt_txdata    = txdata_q;
   assign gt_txcharisk = txk_q;

   // ---------------------------------------------------------------- RX
   logic rx_has_err;
   logic is_good;
   logic is_data;
   logic is_err;

   // Word classification: anything that is neither a clean comma nor a
   // clean all-data word counts as an error.
   always_comb begin
      rx_has_err = (|gt_rxdisperr) | (|gt_rxnotintable);
      is_good    = (gt_rxcharisk == K_ALL) && (gt_rxdata == COMMA) && !rx_has_err;
      is_data    = (gt_rxcharisk == '0) && !rx_has_err;
      is_err     = !is_good && !is_data;
   end

   rx_state_e           state_q, state_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;

   // RX FSM state register with its good-comma and watchdog counters.
   always_ff @(posedge usrclk) begin
      if (reset) begin
         state_q <= ST_HUNT;
         good_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         wdog_q  <= wdog_d;
      end
   end

   // RX FSM next state: hunt for a comma, count consecutive good commas,
   // then stay locked until an error or a comma-free watchdog expiry.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      wdog_d  = wdog_q;
      case (state_q)
         ST_HUNT: begin
            good_d = '0;
            wdog_d = '0;
            if (is_good) begin
               if (LOCK_COUNT <= 1) begin
                  state_d = ST_LOCKED;
               end else begin
                  state_d = ST_CHECK;
                  good_d  = GOOD_W'(1);
               end
            end
         end
         ST_CHECK: begin
            if (is_err) begin
               state_d = ST_HUNT;
               good_d  = '0;
            end else if (is_good) begin
               if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                  state_d = ST_LOCKED;
                  good_d  = '0;
                  wdog_d  = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (is_err) begin
               state_d = ST_HUNT;
               wdog_d  = '0;
            end else if (is_good) begin
               wdog_d = '0;
            end else if (wdog_q == '1) begin
               // Two full comma periods have gone by without a comma.
               state_d = ST_HUNT;
               wdog_d  = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_HUNT;
            good_d  = '0;
            wdog_d  = '0;
         end
      endcase
   end

   logic [DWIDTH-1:0]   rxdata_q, rxdata_d;
   logic                rxvalid_q, rxvalid_d;
   logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

   // RX FSM outputs: lock flag, payload capture and error counter update.
   always_comb begin
      locked    = (state_q == ST_LOCKED);
      rxvalid_d = locked && is_data;
      rxdata_d  = rxvalid_d ? gt_rxdata : rxdata_q;
      if (err_clear) begin
         errcnt_d = '0;
      end else if (is_err && (errcnt_q != '1)) begin
         errcnt_d = errcnt_q + 1'b1;
      end else begin
         errcnt_d = errcnt_q;
      end
   end

   // Registered RX payload strobe and saturating error counter.
   always_ff @(posedge usrclk) begin
      if (reset) begin
         rxdata_q  <= '0;
         rxvalid_q <= 1'b0;
         errcnt_q  <= '0;
      end else begin
         rxdata_q  <= rxdata_d;
         rxvalid_q <= rxvalid_d;
         errcnt_q  <= errcnt_d;
      end
   end

   assign rx_data   = rxdata_q;
   assign rx_valid  = rxvalid_q;
   assign err_count = errcnt_q;
   assign rx_state  = state_q;

endmodule

// File: tb/tb_icc_framer.sv
`timescale 1ns/1ps
// tb_icc_framer: directed bench for icc_framer with a cycle-level reference
// model of the framing rules and an in-order payload scoreboard.
module tb_icc_framer;

   localparam int DW  = 32;
   localparam int DB  = 4;
   localparam int CL  = 4;
   localparam int P   = 16;
   localparam int LC  = 4;
   localparam int EW  = 4;
   localparam int ERR_MAX = (1 << EW) - 1;
   localparam logic [31:0] COMMA_W = 32'hBCBCBCBC;
   localparam int C_GOOD = 0;
   localparam int C_DATA = 1;
   localparam int C_ERR  = 2;

   // ------------------------------------------------ DUT signals
   logic          usrclk;
   logic          reset;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] gt_txdata;
   logic [DB-1:0] gt_txcharisk;
   logic [DW-1:0] gt_rxdata;
   logic [DB-1:0] gt_rxcharisk;
   logic [DB-1:0] gt_rxdisperr;
   logic [DB-1:0] gt_rxnotintable;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          locked;
   logic          err_clear;
   logic [EW-1:0] err_count;
   logic [1:0]    rx_state_dbg;

   logic          loop_en;
   logic [DW-1:0] drv_rxdata;
   logic [DB-1:0] drv_rxk;
   logic [DB-1:0] drv_de;
   logic [DB-1:0] drv_nit;

   assign gt_rxdata       = loop_en ? gt_txdata : drv_rxdata;
   assign gt_rxcharisk    = loop_en ? gt_txcharisk : drv_rxk;
   assign gt_rxdisperr    = drv_de;
   assign gt_rxnotintable = drv_nit;

   icc_framer #(
      .DWIDTH     (DW),
      .COMMA_LOG2 (CL),
      .LOCK_COUNT (LC),
      .ERRCNT_W   (EW)
   ) dut (
      .usrclk          (usrclk),
      .reset           (reset),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .gt_txdata       (gt_txdata),
      .gt_txcharisk    (gt_txcharisk),
      .gt_rxdata       (gt_rxdata),
      .gt_rxcharisk    (gt_rxcharisk),
      .gt_rxdisperr    (gt_rxdisperr),
      .gt_rxnotintable (gt_rxnotintable),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .locked          (locked),
      .err_clear       (err_clear),
      .err_count       (err_count),
      .rx_state        (rx_state_dbg)
   );

   // ------------------------------------------------ clock / reset
   initial begin
      usrclk = 1'b0;
      forever #5 usrclk = ~usrclk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------ check bookkeeping
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input logic [31:0] d, input logic [3:0] k,
                                   input logic [3:0] de, input logic [3:0] nit);
      if ((de != 4'h0) || (nit != 4'h0)) return C_ERR;
      if ((k == 4'hF) && (d == COMMA_W)) return C_GOOD;
      if (k == 4'h0) return C_DATA;
      return C_ERR;
   endfunction

   // ------------------------------------------------ model / scoreboard state
   logic [31:0] exp_q[$];
   bit          sb_en;
   bit          sb_synced;
   int          rx_cnt;
   logic [31:0] first_rx;
   bit          first_rx_seen;

   int          m_cyc;
   int          m_run;
   int          m_quiet;
   bit          m_lock;
   int          cur_k;
   int          phase;
   logic [31:0] e_txd;
   logic [3:0]  e_txk;
   logic        e_rv;
   logic [31:0] e_rd;
   int          e_err;
   bit          last_acc;
   bit          feed;
   int          lock_edge;
   bit          lock_seen;
   int          cls;

   logic        s_rst, s_txv, s_rdy, s_clr;
   logic [31:0] s_txd, s_rd;
   logic [3:0]  s_rk, s_de, s_nit;

   // Reference model: advance on each rising edge from the inputs the DUT
   // sampled, then compare every registered output shortly after the edge.
   always @(posedge usrclk) begin
      s_rst = reset;
      s_txv = tx_valid;
      s_txd = tx_data;
      s_rdy = tx_ready;
      s_clr = err_clear;
      s_rd  = gt_rxdata;
      s_rk  = gt_rxcharisk;
      s_de  = gt_rxdisperr;
      s_nit = gt_rxnotintable;
      last_acc = 1'b0;
      if (s_rst) begin
         m_cyc = 0; m_lock = 1'b0; m_run = 0; m_quiet = 0; cur_k = -1;
         e_txd = COMMA_W; e_txk = 4'hF; e_rv = 1'b0; e_rd = 32'h0; e_err = 0;
         exp_q.delete();
         sb_synced = 1'b0;
      end else begin
         cur_k = m_cyc;
         chk("tx_ready", s_rdy, (m_cyc % P) != 0);
         if (((m_cyc % P) != 0) && s_txv) begin
            e_txd = s_txd; e_txk = 4'h0; last_acc = 1'b1;
            if (sb_en) exp_q.push_back(s_txd);
         end else begin
            e_txd = COMMA_W; e_txk = 4'hF;
         end
         m_cyc++;
         cls = classify(s_rd, s_rk, s_de, s_nit);
         if (m_lock && (cls == C_DATA)) begin
            e_rv = 1'b1; e_rd = s_rd;
         end else begin
            e_rv = 1'b0;
         end
         if (s_clr) e_err = 0;
         else if ((cls == C_ERR) && (e_err < ERR_MAX)) e_err++;
         if (cls == C_ERR) begin
            m_lock = 1'b0; m_run = 0;
         end else if (m_lock) begin
            if (cls == C_GOOD) m_quiet = 0;
            else begin
               m_quiet++;
               if (m_quiet >= 2 * P) begin m_lock = 1'b0; m_run = 0; end
            end
         end else if (cls == C_GOOD) begin
            m_run++;
            if (m_run >= LC) begin m_lock = 1'b1; m_run = 0; m_quiet = 0; end
         end
         if (!m_lock) sb_synced = 1'b0;
      end
      #1;
      chk("gt_txdata", gt_txdata, e_txd);
      chk("gt_txcharisk", gt_txcharisk, e_txk);
      chk("locked", locked, m_lock);
      chk("rx_valid", rx_valid, e_rv);
      chk("rx_data", rx_data, e_rd);
      chk("err_count", err_count, e_err);
      if ((phase == 1) && ((cur_k == 0) || (cur_k == 16) || (cur_k == 32))) begin
         chk("comma_slot_ready", s_rdy, 1'b0);
         chk("comma_slot_data", gt_txdata, 32'hBCBCBCBC);
         chk("comma_slot_k", gt_txcharisk, 4'hF);
      end
      if ((phase == 1) && !lock_seen && (locked === 1'b1)) begin
         lock_seen = 1'b1;
         lock_edge = cur_k;
      end
      if (sb_en && (rx_valid === 1'b1)) begin
         if (!sb_synced) begin
            while ((exp_q.size() > 0) && (exp_q[0] != rx_data)) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL sb_resync: got %0h expected a queued tx word", rx_data);
            end else begin
               void'(exp_q.pop_front());
               sb_synced = 1'b1;
               if (!first_rx_seen) begin first_rx = rx_data; first_rx_seen = 1'b1; end
            end
         end else if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_empty: got %0h expected no rx word", rx_data);
         end else begin
            chk("sb_order", rx_data, exp_q.pop_front());
         end
         rx_cnt++;
      end
   end

   // ------------------------------------------------ driver tasks
   task automatic step();
      @(negedge usrclk);
      if (feed && last_acc) tx_data = tx_data + 32'd1;
   endtask

   task automatic drive_rx(input logic [31:0] d, input logic [3:0] k,
                           input logic [3:0] de, input logic [3:0] nit, input logic clr);
      drv_rxdata = d; drv_rxk = k; drv_de = de; drv_nit = nit; err_clear = clr;
      step();
      err_clear = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   // ------------------------------------------------ directed sequence
   initial begin
      reset = 1'b1; tx_valid = 1'b0; tx_data = 32'h1000_0000; err_clear = 1'b0;
      loop_en = 1'b0; drv_rxdata = 32'h0; drv_rxk = 4'h0; drv_de = 4'h0; drv_nit = 4'h0;
      feed = 1'b0; sb_en = 1'b0; phase = 0; rx_cnt = 0; first_rx = 32'h0;
      first_rx_seen = 1'b0; lock_edge = -1; lock_seen = 1'b0;

      // Loopback with a continuous incrementing stream.
      phase = 1; loop_en = 1'b1; tx_valid = 1'b1; feed = 1'b1; sb_en = 1'b1;
      do_reset(3);
      repeat (120) step();
      chk("lock_edge", lock_edge, 33);
      chk("first_rx", first_rx, 32'h1000_001E);
      chk("rx_count", rx_cnt, 81);
      chk("p1_locked", locked, 1'b1);

      // One disparity error while locked, then relock.
      phase = 2;
      drv_de = 4'b0010; step(); drv_de = 4'h0;
      chk("p2_lock_drop", locked, 1'b0);
      chk("p2_rx_valid", rx_valid, 1'b0);
      chk("p2_err_count", err_count, 4'd1);
      repeat (80) step();
      chk("p2_relock", locked, 1'b1);

      // Watchdog: commas stop arriving while locked.
      phase = 3; loop_en = 1'b0; tx_valid = 1'b0; feed = 1'b0; sb_en = 1'b0;
      do_reset(2);
      repeat (4) drive_rx(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0);
      chk("p3_locked", locked, 1'b1);
      for (int i = 0; i < 20; i++) drive_rx(32'hD000_0000 + i, 4'h0, 4'h0, 4'h0, 1'b0);
      drive_rx(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 31; i++) drive_rx(32'hE000_0000 + i, 4'h0, 4'h0, 4'h0, 1'b0);
      chk("p3_still_locked", locked, 1'b1);
      chk("p3_rx_data", rx_data, 32'hE000_001E);
      drive_rx(32'hE000_001F, 4'h0, 4'h0, 4'h0, 1'b0);
      chk("p3_wdog_drop", locked, 1'b0);

      // Error counter saturation and clear priority.
      phase = 4;
      do_reset(2);
      for (int i = 0; i < 20; i++) begin
         case (i % 4)
            0: drive_rx(32'h1234_5678, 4'h0, 4'b0100, 4'h0, 1'b0);
            1: drive_rx(32'h1234_5678, 4'h0, 4'h0, 4'b1000, 1'b0);
            2: drive_rx(COMMA_W, 4'b0001, 4'h0, 4'h0, 1'b0);
            default: drive_rx(32'hBCBC_BC3C, 4'hF, 4'h0, 4'h0, 1'b0);
         endcase
      end
      chk("p4_saturate", err_count, 4'd15);
      chk("p4_no_lock", locked, 1'b0);
      drive_rx(32'h1234_5678, 4'h0, 4'h1, 4'h0, 1'b1);
      chk("p4_clear_prio", err_count, 4'd0);
      drive_rx(32'h1234_5678, 4'h0, 4'h0, 4'h2, 1'b0);
      chk("p4_count_one", err_count, 4'd1);
      drive_rx(32'h0000_0001, 4'h0, 4'h0, 4'h0, 1'b1);
      chk("p4_clear_only", err_count, 4'd0);
      repeat (2) drive_rx(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0);
      drive_rx(32'h5555_AAAA, 4'h0, 4'h0, 4'h0, 1'b0);
      drive_rx(COMMA_W, 4'hF, 4'h1, 4'h0, 1'b0);
      repeat (3) drive_rx(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0);
      chk("p4_check_restart", locked, 1'b0);
      drive_rx(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0);
      chk("p4_relock", locked, 1'b1);

      // Reset while locked and streaming.
      phase = 5; drv_rxdata = 32'h0; drv_rxk = 4'h0;
      do_reset(2);
      loop_en = 1'b1; tx_valid = 1'b1; feed = 1'b1; sb_en = 1'b1;
      repeat (60) step();
      chk("p5_locked", locked, 1'b1);
      chk("p5_streaming", rx_valid, 1'b1);
      reset = 1'b1;
      step();
      chk("p5_rst_locked", locked, 1'b0);
      chk("p5_rst_rx_valid", rx_valid, 1'b0);
      chk("p5_rst_txk", gt_txcharisk, 4'hF);
      chk("p5_rst_txd", gt_txdata, 32'hBCBCBCBC);
      reset = 1'b0;
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
